// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
`ifndef WORD
`define WORD 64
`endif

package fetch_pkg;

  // Every instruction is one 32-bit word; sequential fetch advances by this.
  localparam int unsigned INSTR_BYTES = 4;

  // Address of the first fetch after reset unless the instance overrides it.
  localparam logic [`WORD-1:0] DEFAULT_RESET_PC = '0;

  // IDLE: waiting for start, REQ: request outstanding to instruction memory,
  // HOLD: instruction offered to decode, HALTED: stopped until reset.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC selection: sequential PC+4 or a word-aligned branch target.
`ifndef WORD
`define WORD 64
`endif

module pc_next
  import fetch_pkg::*;
#(
  parameter int WORD = `WORD
) (
  input  logic [WORD-1:0] pc,
  input  logic            redirect,
  input  logic [WORD-1:0] br_target,
  output logic [WORD-1:0] pc_nxt
);

  // Clears the low address bits so a redirect always lands on an instruction.
  localparam logic [WORD-1:0] ALIGN_MASK = ~WORD'(INSTR_BYTES - 1);

  // Redirect wins; otherwise step one instruction (wraps naturally at 2^WORD).
  always_comb begin
    if (redirect) begin
      pc_nxt = br_target & ALIGN_MASK;
    end else begin
      pc_nxt = pc + WORD'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory request at a time, buffers
// the returned instruction for decode, and handles branch redirects and halt.
`ifndef WORD
`define WORD 64
`endif

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              WORD     = `WORD,
  parameter logic [WORD-1:0] RESET_PC = WORD'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt,
  input  logic            br_taken,
  input  logic [WORD-1:0] br_target,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [WORD-1:0] if_pc,
  input  logic            if_ready,
  output logic            busy
);

  fetch_state_e    state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            halt_pending_q, halt_pending_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [WORD-1:0] if_pc_q, if_pc_d;
  logic [WORD-1:0] pc_nxt;

  // The next-PC mux only matters when the FSM commits it, so it can steer
  // straight off br_taken without looking at the state.
  pc_next #(
    .WORD (WORD)
  ) u_pc_next (
    .pc        (pc_q),
    .redirect  (br_taken),
    .br_target (br_target),
    .pc_nxt    (pc_nxt)
  );

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      halt_pending_q <= 1'b0;
      if_instr_q     <= '0;
      if_pc_q        <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      halt_pending_q <= halt_pending_d;
      if_instr_q     <= if_instr_d;
      if_pc_q        <= if_pc_d;
    end
  end

  // Next state and Moore outputs; branch beats the halt transition beats ack.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    halt_pending_d = halt_pending_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    imem_req       = 1'b0;
    if_valid       = 1'b0;
    busy           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        imem_req       = 1'b1;
        busy           = 1'b1;
        halt_pending_d = halt_pending_q | halt;
        if (br_taken) begin
          // Any ack arriving now belongs to the abandoned path and is dropped.
          pc_d = pc_nxt;
        end else if (imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          pc_d       = pc_nxt;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if_valid       = 1'b1;
        busy           = 1'b1;
        halt_pending_d = halt_pending_q | halt;
        if (br_taken) begin
          // A handshake in this cycle still consumes the held instruction.
          pc_d    = pc_nxt;
          state_d = ST_REQ;
        end else if (if_ready) begin
          state_d = halt_pending_d ? ST_HALTED : ST_REQ;
        end
      end
      ST_HALTED: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (default and wrapping
// reset PC) share stimulus and are compared every cycle against a
// transaction-level model, plus literal spot checks.
`timescale 1ns/1ps

module tb_fetch_sequencer;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_ready = 1'b0;

  logic        req0, valid0, busy0;
  logic [63:0] addr0, ifpc0;
  logic [31:0] instr0;
  logic        req1, valid1, busy1;
  logic [63:0] addr1, ifpc1;
  logic [31:0] instr1;

  int n_checks = 0;
  int n_errors = 0;
  int stepno = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] held;

  always #5 clk = ~clk;

  fetch_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .br_taken(br_taken), .br_target(br_target),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(valid0), .if_instr(instr0), .if_pc(ifpc0), .if_ready(if_ready),
    .busy(busy0)
  );

  fetch_sequencer #(.RESET_PC(WRAP_PC)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .br_taken(br_taken), .br_target(br_target),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(valid1), .if_instr(instr1), .if_pc(ifpc1), .if_ready(if_ready),
    .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: activity phase, halt request, PCs of both instances
  // and the instruction currently offered to decode.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_OFFER = 2, PH_STOP = 3;
  int          phase = PH_IDLE;
  logic        pend = 1'b0;
  logic [31:0] m_instr = '0;
  logic [63:0] m_pc [2] = '{64'h0, WRAP_PC};
  logic [63:0] m_ifpc [2] = '{64'h0, 64'h0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase = PH_IDLE; pend = 1'b0; m_instr = '0;
      m_pc[0] = 64'h0; m_pc[1] = WRAP_PC; m_ifpc[0] = '0; m_ifpc[1] = '0;
    end else begin
      if (phase == PH_FETCH || phase == PH_OFFER) pend = pend | halt;
      if ((phase == PH_FETCH || phase == PH_OFFER) && br_taken) begin
        for (int i = 0; i < 2; i++) m_pc[i] = br_target & ~64'd3;
        phase = PH_FETCH;
      end else if (phase == PH_IDLE) begin
        if (start) phase = PH_FETCH;
      end else if (phase == PH_FETCH) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          for (int i = 0; i < 2; i++) begin
            m_ifpc[i] = m_pc[i];
            m_pc[i]   = m_pc[i] + 64'd4;
          end
          phase = PH_OFFER;
        end
      end else if (phase == PH_OFFER) begin
        if (if_ready) phase = pend ? PH_STOP : PH_FETCH;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("req0",   {63'd0, req0},   {63'd0, phase == PH_FETCH});
    chk("valid0", {63'd0, valid0}, {63'd0, phase == PH_OFFER});
    chk("busy0",  {63'd0, busy0},  {63'd0, phase == PH_FETCH || phase == PH_OFFER});
    chk("addr0",  addr0, m_pc[0]);
    chk("ifpc0",  ifpc0, m_ifpc[0]);
    chk("instr0", {32'd0, instr0}, {32'd0, m_instr});
    chk("req1",   {63'd0, req1},   {63'd0, phase == PH_FETCH});
    chk("valid1", {63'd0, valid1}, {63'd0, phase == PH_OFFER});
    chk("busy1",  {63'd0, busy1},  {63'd0, phase == PH_FETCH || phase == PH_OFFER});
    chk("addr1",  addr1, m_pc[1]);
    chk("ifpc1",  ifpc1, m_ifpc[1]);
    chk("instr1", {32'd0, instr1}, {32'd0, m_instr});
  end

  // Apply one cycle of inputs, then return 2ns after the sampling edge.
  task automatic step(input logic s, input logic h, input logic b, input logic [63:0] tgt,
                      input logic a, input logic r);
    start = s; halt = h; br_taken = b; br_target = tgt; imem_ack = a; if_ready = r;
    imem_rdata = 32'hC0DE_0000 + 32'(stepno);
    last_rdata = imem_rdata;
    stepno++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {63'd0, req0}, 64'd0);
    chk("rst_addr0", addr0, 64'h0);
    chk("rst_addr1", addr1, WRAP_PC);
    chk("rst_valid", {63'd0, valid0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_ifpc", ifpc0, 64'h0);
    chk("rst_instr", {32'd0, instr0}, 64'h0);
    reset = 1'b1;

    // IDLE ignores halt, branch and ack.
    step(0, 1, 1, 64'h40, 1, 1);
    chk("idle_addr", addr0, 64'h0);
    chk("idle_busy", {63'd0, busy0}, 64'd0);

    // Sequential fetch with ack two cycles into each request.
    step(1, 0, 0, 64'h0, 0, 1);
    chk("start_req", {63'd0, req0}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 64'h0, 0, 1);
      step(0, 0, 0, 64'h0, 1, 1);
      chk("seq_valid", {63'd0, valid0}, 64'd1);
      chk("seq_ifpc", ifpc0, 64'(k * 4));
      chk("seq_instr", {32'd0, instr0}, {32'd0, last_rdata});
      chk("wrap_ifpc", ifpc1, (k == 0) ? WRAP_PC : 64'((k - 1) * 4));
      step(0, 0, 0, 64'h0, 0, 1);
    end

    // Decode stalls in HOLD; stray acks must not disturb the buffer.
    step(0, 0, 0, 64'h0, 1, 0);
    held = last_rdata;
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, 64'h0, 1, 0);
      chk("stall_valid", {63'd0, valid0}, 64'd1);
      chk("stall_ifpc", ifpc0, 64'hC);
      chk("stall_instr", {32'd0, instr0}, {32'd0, held});
      chk("stall_req", {63'd0, req0}, 64'd0);
    end
    step(0, 0, 0, 64'h0, 0, 1);
    chk("after_stall_addr", addr0, 64'h10);

    // Branch coinciding with ack: data dropped, aligned target requested.
    step(0, 0, 1, 64'h103, 1, 1);
    chk("br_ack_req", {63'd0, req0}, 64'd1);
    chk("br_ack_addr", addr0, 64'h100);
    chk("br_ack_addr1", addr1, 64'h100);
    chk("br_ack_valid", {63'd0, valid0}, 64'd0);
    chk("br_ack_ifpc", ifpc0, 64'hC);
    step(0, 0, 0, 64'h0, 1, 0);
    chk("br_fetch_ifpc", ifpc0, 64'h100);

    // Branch during a HOLD handshake wins.
    step(0, 0, 1, 64'h201, 0, 1);
    chk("br_hs_addr", addr0, 64'h200);
    chk("br_hs_valid", {63'd0, valid0}, 64'd0);

    // Halt in REQ, then a branch keeps the pending halt.
    step(0, 1, 0, 64'h0, 0, 0);
    step(0, 0, 1, 64'h300, 0, 0);
    chk("halt_br_addr", addr0, 64'h300);
    step(0, 0, 0, 64'h0, 1, 0);
    chk("halt_deliver_ifpc", ifpc0, 64'h300);
    chk("halt_deliver_valid", {63'd0, valid0}, 64'd1);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("halted_busy", {63'd0, busy0}, 64'd0);
    chk("halted_valid", {63'd0, valid0}, 64'd0);
    step(1, 0, 0, 64'h0, 1, 1);
    step(1, 0, 0, 64'h0, 0, 1);
    chk("halted_start_busy", {63'd0, busy0}, 64'd0);
    chk("halted_start_req", {63'd0, req0}, 64'd0);

    // Leave HALTED via reset, then assert reset between edges during REQ.
    reset = 1'b0;
    step(0, 0, 0, 64'h0, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 64'h0, 0, 0);
    step(0, 0, 0, 64'h0, 1, 0);
    chk("pre_rst_valid", {63'd0, valid0}, 64'd1);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("pre_rst_req", {63'd0, req0}, 64'd1);
    chk("pre_rst_addr", addr0, 64'h4);
    #1 reset = 1'b0;
    #1;
    chk("async_req", {63'd0, req0}, 64'd0);
    chk("async_valid", {63'd0, valid0}, 64'd0);
    chk("async_addr", addr0, 64'h0);
    chk("async_ifpc", ifpc0, 64'h0);
    @(posedge clk);
    #2;
    step(0, 0, 0, 64'h0, 1, 1);
    reset = 1'b1;
    step(0, 0, 0, 64'h0, 1, 1);
    chk("late_ack_valid", {63'd0, valid0}, 64'd0);
    chk("late_ack_busy", {63'd0, busy0}, 64'd0);
    chk("late_ack_instr", {32'd0, instr0}, 64'h0);
    step(0, 0, 0, 64'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-002 Parameter WORD, default `WORD (64), SHALL set the width of every address and PC field.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-low; reset=0 clears all state immediately.
REQ-005 start  in  1  level; begins fetching from IDLE.
REQ-006 halt  in  1  pulse; requests stop after the current instruction.
REQ-007 br_taken  in  1  pulse; redirects the PC.
REQ-008 br_target  in  WORD  redirect address.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  WORD  fetch address, equals current PC.
REQ-011 imem_ack  in  1  memory done; imem_rdata valid this cycle.
REQ-012 imem_rdata  in  32  fetched instruction.
REQ-013 if_valid  out  1  instruction available to decode.
REQ-014 if_instr  out  32  buffered instruction.
REQ-015 if_pc  out  WORD  address of if_instr.
REQ-016 if_ready  in  1  decode accepts when if_valid && if_ready.
REQ-017 busy  out  1  high in any state other than IDLE and HALTED.

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD and HALTED.
REQ-019 In IDLE, start=1 SHALL move to REQ next cycle; halt and br_taken SHALL be ignored.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC; the request SHALL stay asserted until imem_ack.
REQ-021 On imem_ack in REQ: if_instr<=imem_rdata, if_pc<=PC, PC<=PC+4, move to HOLD; if_valid SHALL go high exactly 1 cycle after ack.
REQ-022 In HOLD, imem_req SHALL be 0 and if_valid SHALL be 1; if_instr and if_pc SHALL hold until handshake.
REQ-023 On a HOLD handshake: next state REQ, or HALTED if halt_pending.
REQ-024 halt SHALL set a sticky halt_pending flag in REQ or HOLD; HALTED SHALL be left only by reset.
REQ-025 br_taken in REQ or HOLD SHALL set PC<=br_target with bits[1:0] forced to 00, drop if_valid, and move to REQ.
REQ-026 Priority SHALL be reset > br_taken > halt-transition > imem_ack.
REQ-027 An imem_ack coinciding with br_taken SHALL be discarded; the redirected request SHALL issue next cycle.
REQ-028 br_taken during a HOLD handshake SHALL win; the accepted instruction counts as consumed, and the next fetch SHALL be br_target.
REQ-029 br_taken with halt_pending set SHALL redirect and SHALL keep halt_pending.
REQ-030 PC+4 SHALL wrap modulo 2^WORD (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-031 imem_ack outside REQ SHALL be ignored.

Reset
REQ-032 While reset=0: state=IDLE, PC=RESET_PC, halt_pending=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, busy=0.
REQ-033 Reset asserted mid-request SHALL drop imem_req asynchronously; any later ack SHALL be ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, INSTR_BYTES=4 and the default RESET_PC; WORD SHALL come from the existing `WORD define.
REQ-035 Next-PC selection (PC+4 vs aligned br_target) SHALL be one combinational sub-module, pc_next.

Verification
REQ-036 reset, start=1, ack 2 cycles after each req, if_ready=1 -> if_pc sequence 0,4,8 with matching if_instr.
REQ-037 if_ready=0 for 3 cycles in HOLD -> if_valid, if_instr, if_pc stable and imem_req=0 throughout.
REQ-038 br_taken, br_target=64'h103, same cycle as ack -> ack data dropped, next imem_addr=64'h100.
REQ-039 halt pulse in REQ -> current instruction delivered, then HALTED with busy=0; start afterwards has no effect.
REQ-040 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> if_pc FFFF_FFFF_FFFF_FFFC then 0.
REQ-041 reset asserted between edges during REQ -> imem_req=0 and if_valid=0 immediately, before the next clock edge.
